// File: rtl/uart_baud_gen_prog.sv
// uart_baud_gen_prog
//   Run-time programmable fractional baud generator built as an NCO. A
//   W-bit phase accumulator adds the current increment each cycle; every
//   carry out of the accumulator is one oversample tick. An oversample
//   counter derives the bit tick and the mid-bit tick from those carries, so
//   all three ticks stay phase-locked. New increments are shadow-loaded and
//   only take effect on a carry cycle, or while idle or resyncing. This keeps
//   a baud change from ever cutting a tick period short.
//
// Ports
//   clk       in   system clock, all logic on posedge
//   rst       in   synchronous active-high reset
//   enable    in   1 = run, 0 = hold phase cleared
//   inc_wr    in   write strobe for inc_data
//   inc_data  in   [ACC_WIDTH-1:0] new increment (tick rate = CLK_FREQ*inc/2^W)
//   resync    in   1-cycle pulse, realign phase to a start-bit edge
//   os_tick   out  oversample tick, 1-cycle pulse
//   bit_tick  out  end of bit period, 1-cycle pulse
//   mid_tick  out  bit centre sample point, 1-cycle pulse
//   os_phase  out  [CNT_W-1:0] current oversample index
//   inc_busy  out  a written increment is pending, not yet applied
module uart_baud_gen_prog #(
  parameter int unsigned CLK_FREQ     = 12000000,
  parameter int unsigned DEFAULT_BAUD = 115200,
  parameter int unsigned OVERSAMPLING = 16,
  parameter int unsigned ACC_WIDTH    = 24,
  localparam int unsigned CNT_W       = (OVERSAMPLING > 1) ? $clog2(OVERSAMPLING) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 inc_wr,
  input  logic [ACC_WIDTH-1:0] inc_data,
  input  logic                 resync,
  output logic                 os_tick,
  output logic                 bit_tick,
  output logic                 mid_tick,
  output logic [CNT_W-1:0]     os_phase,
  output logic                 inc_busy
);

  // Rounded reset increment, evaluated in 64-bit arithmetic.
  localparam logic [63:0] DEFAULT_INC_64 =
    (((64'(DEFAULT_BAUD) * 64'(OVERSAMPLING)) << ACC_WIDTH) + (64'(CLK_FREQ) / 64'd2))
    / 64'(CLK_FREQ);
  localparam logic [ACC_WIDTH-1:0] DEFAULT_INC = DEFAULT_INC_64[ACC_WIDTH-1:0];

  // The counter value seen on the carry that ends a bit.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(OVERSAMPLING - 1);
  // The counter value seen on the carry that reaches the bit centre, i.e.
  // os_cnt+1 == OVERSAMPLING/2. With a single oversample, the centre collapses
  // onto the bit tick.
  localparam logic [CNT_W-1:0] MID_IDX =
    CNT_W'((OVERSAMPLING > 1) ? (OVERSAMPLING / 2 - 1) : 0);

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     os_cnt_q, os_cnt_d;
  logic [ACC_WIDTH-1:0] inc_cur_q, inc_cur_d;
  logic [ACC_WIDTH-1:0] inc_pend_q, inc_pend_d;
  logic                 inc_busy_q, inc_busy_d;
  logic                 os_tick_q, os_tick_d;
  logic                 bit_tick_q, bit_tick_d;
  logic                 mid_tick_q, mid_tick_d;

  logic [ACC_WIDTH:0]   sum_s;
  logic                 carry_s;
  logic                 run_s;

  // Next-state logic: accumulator, oversample counter, ticks and increment shadow.
  always_comb begin
    sum_s      = {1'b0, acc_q} + {1'b0, inc_cur_q};
    carry_s    = sum_s[ACC_WIDTH];
    run_s      = enable & ~resync;

    acc_d      = acc_q;
    os_cnt_d   = os_cnt_q;
    inc_cur_d  = inc_cur_q;
    inc_pend_d = inc_pend_q;
    inc_busy_d = inc_busy_q;
    os_tick_d  = 1'b0;
    bit_tick_d = 1'b0;
    mid_tick_d = 1'b0;

    if (run_s) begin
      acc_d      = sum_s[ACC_WIDTH-1:0];
      os_tick_d  = carry_s;
      bit_tick_d = carry_s & (os_cnt_q == LAST_IDX);
      mid_tick_d = carry_s & (os_cnt_q == MID_IDX);
      if (carry_s) begin
        if (os_cnt_q == LAST_IDX) begin
          os_cnt_d = '0;
        end else begin
          os_cnt_d = os_cnt_q + CNT_W'(1);
        end
      end else begin
        os_cnt_d = os_cnt_q;
      end
    end else begin
      // Resync and disable both restart the phase from zero.
      acc_d    = '0;
      os_cnt_d = '0;
    end

    // A fresh write always takes precedence and keeps the value pending.
    // Otherwise, the pending value is only applied at a period boundary
    // (carry), or while the phase is being restarted anyway.
    if (inc_wr) begin
      inc_pend_d = inc_data;
      inc_busy_d = 1'b1;
    end else if (~run_s | carry_s) begin
      inc_cur_d  = inc_pend_q;
      inc_busy_d = 1'b0;
    end else begin
      inc_busy_d = inc_busy_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      os_cnt_q   <= '0;
      inc_cur_q  <= DEFAULT_INC;
      inc_pend_q <= DEFAULT_INC;
      inc_busy_q <= 1'b0;
      os_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
      mid_tick_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      os_cnt_q   <= os_cnt_d;
      inc_cur_q  <= inc_cur_d;
      inc_pend_q <= inc_pend_d;
      inc_busy_q <= inc_busy_d;
      os_tick_q  <= os_tick_d;
      bit_tick_q <= bit_tick_d;
      mid_tick_q <= mid_tick_d;
    end
  end

  assign os_tick  = os_tick_q;
  assign bit_tick = bit_tick_q;
  assign mid_tick = mid_tick_q;
  assign os_phase = os_cnt_q;
  assign inc_busy = inc_busy_q;

endmodule

// File: tb/tb_uart_baud_gen_prog.sv
// Bench for uart_baud_gen_prog with W=8, OVERSAMPLING=4 and a default
// increment of 64 (CLK_FREQ=1600, DEFAULT_BAUD=100). The reference model
// tracks an unbounded phase P. The oversample tick count is P / 2^W, and
// tick kinds follow from that count modulo OVERSAMPLING.
module tb_uart_baud_gen_prog;
  localparam int W       = 8;
  localparam int OS      = 4;
  localparam int DEF_INC = 64;

  logic         clk = 1'b0;
  logic         rst, enable, inc_wr, resync;
  logic [W-1:0] inc_data;
  logic         os_tick, bit_tick, mid_tick, inc_busy;
  logic [1:0]   os_phase;

  int total = 0;
  int bad   = 0;

  uart_baud_gen_prog #(
    .CLK_FREQ(1600), .DEFAULT_BAUD(100), .OVERSAMPLING(OS), .ACC_WIDTH(W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .inc_wr(inc_wr), .inc_data(inc_data),
    .resync(resync), .os_tick(os_tick), .bit_tick(bit_tick), .mid_tick(mid_tick),
    .os_phase(os_phase), .inc_busy(inc_busy)
  );

  always #5 clk = ~clk;

  // Model state.
  longint m_p;
  int     m_cur, m_pend;
  bit     m_busy, m_os, m_bit, m_mid, m_valid = 1'b0;

  always @(posedge clk) begin : model
    longint np;
    bit     run, carry;
    if (rst) begin
      m_p = 0; m_cur = DEF_INC; m_pend = DEF_INC; m_busy = 1'b0;
      m_os = 1'b0; m_bit = 1'b0; m_mid = 1'b0; m_valid = 1'b1;
    end else begin
      run   = enable && !resync;
      np    = m_p + m_cur;
      carry = run && ((np >> W) != (m_p >> W));
      if (run) begin
        m_os  = carry;
        m_bit = carry && (((np >> W) % OS) == 0);
        m_mid = carry && (((np >> W) % OS) == OS / 2);
        m_p   = np;
      end else begin
        m_p = 0; m_os = 1'b0; m_bit = 1'b0; m_mid = 1'b0;
      end
      if (inc_wr) begin
        m_pend = int'(inc_data); m_busy = 1'b1;
      end else if (!run || carry) begin
        m_cur = m_pend; m_busy = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("os_tick",  longint'(os_tick),  longint'(m_os));
      chk("bit_tick", longint'(bit_tick), longint'(m_bit));
      chk("mid_tick", longint'(mid_tick), longint'(m_mid));
      chk("os_phase", longint'(os_phase), (m_p >> W) % OS);
      chk("inc_busy", longint'(inc_busy), longint'(m_busy));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Count cycles until the selected output is high (0=os,1=bit,2=mid,3=phase==2).
  task automatic wait_evt(input int which, input int limit, output int n);
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < limit) begin
      step();
      n++;
      case (which)
        0: hit = os_tick;
        1: hit = bit_tick;
        2: hit = mid_tick;
        default: hit = (os_phase == 2'd2);
      endcase
    end
    if (!hit) begin
      total++;
      bad++;
      $display("FAIL wait_evt%0d: no event within %0d cycles", which, limit);
      n = -1;
    end
  endtask

  task automatic write_inc(input int v);
    inc_wr = 1'b1;
    inc_data = v[W-1:0];
    step();
    inc_wr = 1'b0;
  endtask

  task automatic pulse_resync();
    resync = 1'b1;
    step();
    resync = 1'b0;
  endtask

  initial begin
    int n, cnt;
    rst = 1'b1; enable = 1'b0; inc_wr = 1'b0; resync = 1'b0; inc_data = '0;
    repeat (3) step();
    chk("rst_os",    longint'(os_tick),  0);
    chk("rst_busy",  longint'(inc_busy), 0);
    chk("rst_phase", longint'(os_phase), 0);

    // Default increment 64: os every 4, bit every 16, mid 8 after bit.
    rst = 1'b0; enable = 1'b1;
    wait_evt(1, 40, n); chk("first_bit", n, 16);
    wait_evt(2, 40, n); chk("mid_after_bit", n, 8);
    wait_evt(1, 40, n); chk("bit_after_mid", n, 8);
    wait_evt(0, 40, n); chk("os_gap64", n, 4);

    // Shadow write of 32 just after a tick: old period finishes, then gap 8.
    write_inc(32);
    chk("busy_after_wr", longint'(inc_busy), 1);
    wait_evt(0, 40, n); chk("old_period_rest", n, 3);
    chk("busy_cleared", longint'(inc_busy), 0);
    wait_evt(0, 40, n); chk("new_gap32", n, 8);

    // Increment 96: first tick at 3, then gaps 3,2,3.
    write_inc(96);
    pulse_resync();
    wait_evt(0, 40, n); chk("first96", n, 3);
    wait_evt(0, 40, n); chk("gap96_a", n, 3);
    wait_evt(0, 40, n); chk("gap96_b", n, 2);
    wait_evt(0, 40, n); chk("gap96_c", n, 3);

    // Resync at os_phase 2.
    write_inc(64);
    pulse_resync();
    wait_evt(3, 40, n);
    pulse_resync();
    chk("rs_os",    longint'(os_tick),  0);
    chk("rs_bit",   longint'(bit_tick), 0);
    chk("rs_mid",   longint'(mid_tick), 0);
    chk("rs_phase", longint'(os_phase), 0);
    wait_evt(2, 40, n); chk("rs_mid_delay", n, 8);

    // Disabled for 10 cycles, write 128 meanwhile: applied while idle.
    enable = 1'b0;
    step(); step();
    write_inc(128);
    chk("dis_busy_wr", longint'(inc_busy), 1);
    step();
    chk("dis_busy_applied", longint'(inc_busy), 0);
    repeat (6) step();
    enable = 1'b1;
    wait_evt(0, 40, n); chk("en_first128", n, 2);
    wait_evt(0, 40, n); chk("gap128", n, 2);

    // Reset with a pending write: default increment is restored.
    write_inc(32);
    chk("pre_rst_busy", longint'(inc_busy), 1);
    rst = 1'b1;
    step();
    chk("mid_rst_busy", longint'(inc_busy), 0);
    chk("mid_rst_os",   longint'(os_tick),  0);
    rst = 1'b0;
    wait_evt(0, 40, n); chk("post_rst_first", n, 4);
    wait_evt(0, 40, n); chk("post_rst_gap", n, 4);

    // Increment 0: no ticks.
    write_inc(0);
    pulse_resync();
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (os_tick) cnt++;
    end
    chk("inc0_ticks", cnt, 0);

    // Back-to-back writes: last one (128) wins.
    inc_wr = 1'b1; inc_data = 8'd16;
    step();
    inc_data = 8'd128;
    step();
    inc_wr = 1'b0;
    pulse_resync();
    wait_evt(0, 40, n); chk("b2b_first", n, 2);
    wait_evt(0, 40, n); chk("b2b_gap", n, 2);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
